tmip_seq: RTL and testbench

TMIP_SEQ -- requirements
Module: tmip_seq

---
 rtl/tmip_seq.sv | 181 ++++++++++++++++++
 tb/tb_tmip_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmip_seq.sv
// Image-transform sequencer: buffers a list of actions, folds the flips into
// flags and issues MAXPOOL/CORR commands to an external engine.
module tmip_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    input  logic [4:0] cfg_size,
    input  logic       act_valid,
    input  logic [1:0] act,
    input  logic       act_last,
    output logic       act_ready,
    output logic       eng_start,
    output logic       eng_op,
    output logic [4:0] eng_size,
    output logic       eng_hflip,
    output logic       eng_vflip,
    input  logic       eng_done,
    output logic       busy,
    output logic       seq_done,
    output logic       err,
    output logic [4:0] cur_size
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ACT_MAXPOOL = 2'd0,
        ACT_HFLIP   = 2'd1,
        ACT_VFLIP   = 2'd2,
        ACT_CORR    = 2'd3
    } act_t;

    state_t     r_state;
    state_t     w_next;
    act_t       r_fifo [8];
    logic [2:0] r_wptr;
    logic [2:0] r_rptr;
    logic [3:0] r_count;
    logic [4:0] r_cur_size;
    logic       r_hflip;
    logic       r_vflip;
    logic       r_err;
    logic       r_last_corr;
    logic       r_mp_pend;
    logic       r_eng_op;
    logic [4:0] r_eng_size;
    logic       r_eng_hflip;
    logic       r_eng_vflip;

    logic       w_cfg_legal;
    logic       w_cfg_load;
    logic       w_full;
    logic       w_empty;
    logic       w_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_start;
    logic       w_start_op;
    act_t       w_head;

    assign w_cfg_legal = (cfg_size == 5'd4) || (cfg_size == 5'd8) || (cfg_size == 5'd16);
    assign w_cfg_load  = !rst_n && (r_state == S_IDLE) && cfg_valid && w_cfg_legal;
    assign w_full      = (r_count == 4'd8);
    assign w_empty     = (r_count == 4'd0);
    assign w_ready     = !rst_n && (r_state == S_LOAD) && !w_full;
    assign w_push      = act_valid && w_ready;
    assign w_head      = r_fifo[r_rptr];

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_start    = 1'b0;
        w_start_op = 1'b0;
        if (!rst_n) begin
            unique case (r_state)
                S_IDLE: if (w_cfg_load) w_next = S_LOAD;
                S_LOAD: if (w_push && act_last) w_next = S_ISSUE;
                S_ISSUE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        unique case (w_head)
                            ACT_MAXPOOL: begin
                                if (r_cur_size != 5'd4) begin
                                    w_start = 1'b1;
                                    w_next  = S_WAIT;
                                end
                            end
                            ACT_CORR: begin
                                w_start    = 1'b1;
                                w_start_op = 1'b1;
                                w_next     = S_WAIT;
                            end
                            default: ;
                        endcase
                    end else if (!r_last_corr) begin
                        // sequence must end with a correlation
                        w_start    = 1'b1;
                        w_start_op = 1'b1;
                        w_next     = S_WAIT;
                    end else begin
                        w_next = S_DONE;
                    end
                end
                S_WAIT: if (eng_done) w_next = S_ISSUE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= act_t'(act);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_cur_size  <= '0;
            r_hflip     <= 1'b0;
            r_vflip     <= 1'b0;
            r_err       <= 1'b0;
            r_last_corr <= 1'b0;
            r_mp_pend   <= 1'b0;
            r_eng_op    <= 1'b0;
            r_eng_size  <= '0;
            r_eng_hflip <= 1'b0;
            r_eng_vflip <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cfg_load) begin
                r_cur_size  <= cfg_size;
                r_hflip     <= 1'b0;
                r_vflip     <= 1'b0;
                r_err       <= 1'b0;
                r_last_corr <= 1'b0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_count     <= '0;
            end else begin
                if (r_state == S_IDLE && cfg_valid) r_err <= 1'b1;
                if (w_push) r_wptr <= r_wptr + 3'd1;
                if (w_pop)  r_rptr <= r_rptr + 3'd1;
                r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
            end
            if (w_pop && w_head == ACT_HFLIP) r_hflip <= !r_hflip;
            if (w_pop && w_head == ACT_VFLIP) r_vflip <= !r_vflip;
            if (w_start) begin
                r_eng_op    <= w_start_op;
                r_eng_size  <= r_cur_size;
                r_eng_hflip <= r_hflip;
                r_eng_vflip <= r_vflip;
                r_last_corr <= w_start_op;
                r_mp_pend   <= !w_start_op;
            end
            if (r_state == S_WAIT && eng_done && r_mp_pend) r_cur_size <= r_cur_size >> 1;
        end
    end

    // Outputs are gated by reset so they read zero from the first reset cycle on;
    // command fields bypass their hold registers in the eng_start cycle.
    assign act_ready = w_ready;
    assign eng_start = w_start;
    assign eng_op    = !rst_n && (w_start ? w_start_op : r_eng_op);
    assign eng_size  = rst_n ? '0 : (w_start ? r_cur_size : r_eng_size);
    assign eng_hflip = !rst_n && (w_start ? r_hflip : r_eng_hflip);
    assign eng_vflip = !rst_n && (w_start ? r_vflip : r_eng_vflip);
    assign busy      = !rst_n && (r_state != S_IDLE);
    assign seq_done  = !rst_n && (r_state == S_DONE);
    assign err       = !rst_n && r_err;
    assign cur_size  = rst_n ? '0 : r_cur_size;

endmodule

// File: tb/tb_tmip_seq.sv
// Scoreboard bench for tmip_seq: expected engine commands are queued by the
// stimulus and checked by a monitor whenever eng_start fires.
module tb_tmip_seq;

    localparam logic [1:0] MP = 2'd0;
    localparam logic [1:0] HF = 2'd1;
    localparam logic [1:0] VF = 2'd2;
    localparam logic [1:0] CR = 2'd3;

    typedef struct packed {
        logic       op;
        logic [4:0] size;
        logic       hf;
        logic       vf;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic [4:0] cfg_size;
    logic       act_valid;
    logic [1:0] act;
    logic       act_last;
    logic       act_ready;
    logic       eng_start;
    logic       eng_op;
    logic [4:0] eng_size;
    logic       eng_hflip;
    logic       eng_vflip;
    logic       eng_done;
    logic       eng_done_auto;
    logic       eng_done_stray;
    logic       busy;
    logic       seq_done;
    logic       err;
    logic [4:0] cur_size;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   exp_done = 0;
    int   start_cnt = 0;
    int   last_start_cyc = 0;
    bit   eng_auto = 1'b1;
    logic prev_start = 1'b0;
    cmd_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign eng_done = eng_done_auto | eng_done_stray;

    tmip_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_size  (cfg_size),
        .act_valid (act_valid),
        .act       (act),
        .act_last  (act_last),
        .act_ready (act_ready),
        .eng_start (eng_start),
        .eng_op    (eng_op),
        .eng_size  (eng_size),
        .eng_hflip (eng_hflip),
        .eng_vflip (eng_vflip),
        .eng_done  (eng_done),
        .busy      (busy),
        .seq_done  (seq_done),
        .err       (err),
        .cur_size  (cur_size)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    function automatic logic [17:0] outs();
        return {act_ready, eng_start, eng_op, eng_size, eng_hflip, eng_vflip,
                busy, seq_done, err, cur_size};
    endfunction

    task automatic push_cmd(input logic op, input logic [4:0] sz, input logic hf, input logic vf);
        exp_q.push_back(cmd_t'{op, sz, hf, vf});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [4:0] s);
        cfg_valid = 1'b1;
        cfg_size  = s;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("outputs_during_reset", outs(), 0);
        step();
        step();
        rst_n = 1'b0;
    endtask

    task automatic send_act(input logic [1:0] a, input logic l, input int budget,
                            output bit ok, output int acc_cyc);
        act_valid = 1'b1;
        act       = a;
        act_last  = l;
        ok        = 1'b0;
        acc_cyc   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (act_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        act_valid = 1'b0;
        act_last  = 1'b0;
        if (ok) acc_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("timeout_waiting_idle");
    endtask

    // Monitor: every eng_start consumes one expected command
    always @(negedge clk) begin
        cmd_t e;
        if (eng_start) begin
            chk("eng_start_back_to_back", prev_start, 0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_eng_start");
            end else begin
                e = exp_q.pop_front();
                chk("eng_op", eng_op, e.op);
                chk("eng_size", eng_size, e.size);
                if (e.op) begin
                    chk("eng_hflip", eng_hflip, e.hf);
                    chk("eng_vflip", eng_vflip, e.vf);
                end
            end
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (seq_done) begin
            if (exp_done == 0) fail_now("unexpected_seq_done");
            else begin
                n_checks++;
                n_pass++;
                exp_done--;
            end
        end
        prev_start = eng_start;
    end

    // Engine model: completion pulse a fixed delay after each command
    initial begin
        eng_done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start && eng_auto) begin
                repeat (3) @(posedge clk);
                #1 eng_done_auto = 1'b1;
                @(posedge clk);
                #1 eng_done_auto = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int acc;
        int c;
        int s0;
        bit seen;
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_size = '0;
        act_valid = 1'b0; act = '0; act_last = 1'b0; eng_done_stray = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_init", outs(), 0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy, act_ready, err, cur_size}, 0);
        step();

        // MAXPOOL x3 + CORR at 16: third MAXPOOL at size 4 is a no-op
        s0 = start_cnt;
        push_cmd(0, 16, 0, 0); push_cmd(0, 8, 0, 0); push_cmd(1, 4, 0, 0);
        exp_done++;
        do_cfg(16);
        @(negedge clk);
        chk("load_after_cfg16", {busy, act_ready, cur_size}, {1'b1, 1'b1, 5'd16});
        step();
        acc = 0;
        send_act(MP, 0, 5, ok, c); acc += int'(ok);
        send_act(MP, 0, 5, ok, c); acc += int'(ok);
        send_act(MP, 0, 5, ok, c); acc += int'(ok);
        send_act(CR, 1, 5, ok, c); acc += int'(ok);
        chk("t1_accepts", acc, 4);
        wait_idle(300);
        chk("t1_cmds_drained", exp_q.size(), 0);
        chk("t1_seq_done_seen", exp_done, 0);
        chk("t1_start_count", start_cnt - s0, 3);
        chk("t1_cur_size_persist", cur_size, 4);
        step();

        // flips only: implicit CORR carries hflip 0, vflip 1
        s0 = start_cnt;
        push_cmd(1, 8, 0, 1);
        exp_done++;
        do_cfg(8);
        send_act(HF, 0, 5, ok, c);
        send_act(VF, 0, 5, ok, c);
        send_act(HF, 1, 5, ok, acc);
        wait_idle(300);
        chk("t2_issue_to_start_latency", last_start_cyc - acc, 3);
        chk("t2_start_count", start_cnt - s0, 1);
        chk("t2_seq_done_seen", exp_done, 0);
        chk("t2_cmd_fields_hold", {eng_op, eng_size, eng_hflip, eng_vflip},
            {1'b1, 5'd8, 1'b0, 1'b1});
        step();

        // illegal size then legal size
        do_cfg(5);
        @(negedge clk);
        chk("t3_illegal_cfg", {err, busy, act_ready, cur_size}, {1'b1, 1'b0, 1'b0, 5'd8});
        step();
        do_cfg(4);
        @(negedge clk);
        chk("t3_legal_cfg", {err, busy, act_ready, cur_size}, {1'b0, 1'b1, 1'b1, 5'd4});
        step();

        // full FIFO stall: 8 accepts, 9th refused
        s0 = start_cnt;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            send_act(HF, 0, 3, ok, c);
            acc += int'(ok);
        end
        chk("t4_accepts", acc, 8);
        @(negedge clk);
        chk("t4_ready_drops_when_full", {act_ready, busy}, {1'b0, 1'b1});
        step();
        send_act(CR, 1, 10, ok, c);
        chk("t4_ninth_not_accepted", ok, 0);
        do_reset();
        @(negedge clk);
        chk("t4_outputs_after_reset", outs(), 0);
        chk("t4_no_eng_start", start_cnt - s0, 0);
        step();

        // reset while waiting for the engine, then a stray eng_done
        s0 = start_cnt;
        eng_auto = 1'b0;
        push_cmd(0, 16, 0, 0);
        do_cfg(16);
        send_act(MP, 0, 5, ok, c);
        send_act(CR, 1, 5, ok, c);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_cnt > s0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("t5_timeout_waiting_start");
        step();
        step();
        do_reset();
        eng_done_stray = 1'b1;
        step();
        eng_done_stray = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_outputs_after_abort", outs(), 0);
        chk("t5_start_count", start_cnt - s0, 1);
        chk("t5_cmds_drained", exp_q.size(), 0);
        eng_auto = 1'b1;
        step();

        // CORR then MAXPOOL at 8: trailing implicit CORR at 4
        s0 = start_cnt;
        push_cmd(1, 8, 0, 0); push_cmd(0, 8, 0, 0); push_cmd(1, 4, 0, 0);
        exp_done++;
        do_cfg(8);
        send_act(CR, 0, 5, ok, c);
        send_act(MP, 1, 5, ok, c);
        wait_idle(300);
        chk("t6_cmds_drained", exp_q.size(), 0);
        chk("t6_seq_done_seen", exp_done, 0);
        chk("t6_start_count", start_cnt - s0, 3);
        chk("t6_cur_size", cur_size, 4);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
